// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 keycode constants used by the decoder and the fighter controller
package ps2_pkg;
  localparam int KC_BRK = 9;
  localparam int KC_EXT = 8;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  typedef logic [9:0] keycode_t;
  localparam keycode_t KEY_UP          = 10'h175;
  localparam keycode_t KEY_DOWN        = 10'h172;
  localparam keycode_t KEY_LEFT        = 10'h16B;
  localparam keycode_t KEY_RIGHT       = 10'h174;
  localparam keycode_t KEY_UP_BREAK    = 10'h375;
  localparam keycode_t KEY_DOWN_BREAK  = 10'h372;
  localparam keycode_t KEY_LEFT_BREAK  = 10'h36B;
  localparam keycode_t KEY_RIGHT_BREAK = 10'h374;
  localparam keycode_t KEY_1           = 10'h069;
  localparam keycode_t KEY_2           = 10'h072;
  localparam keycode_t KEY_3           = 10'h07A;
  localparam keycode_t KEY_4           = 10'h06B;
  localparam keycode_t KEY_5           = 10'h073;
  localparam keycode_t KEY_6           = 10'h074;
  // Keyboard status/ack bytes that never carry a key press
  function automatic logic is_discard(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: oversampling PS/2 frame receiver with start/stop/odd-parity check and idle watchdog
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_busy
);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  logic [SYNC_STAGES-1:0] r_csync, r_dsync;
  logic                   r_prev;
  logic [1:0]             r_state;
  logic [3:0]             r_cnt;
  logic [10:0]            r_sr;
  logic [WDW-1:0]         r_wd;
  logic                   w_clk, w_data, w_fall, w_ok;
  assign w_clk  = r_csync[SYNC_STAGES-1];
  assign w_data = r_dsync[SYNC_STAGES-1];
  assign w_fall = r_prev & ~w_clk;
  // Shift register holds {stop, parity, d7..d0, start}
  assign w_ok   = ~r_sr[0] & r_sr[10] & ^r_sr[9:1];
  assign o_busy = r_state != S_IDLE;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_csync      <= '1;
      r_dsync      <= '1;
      r_prev       <= 1'b1;
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sr         <= '0;
      r_wd         <= '0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      r_csync      <= {r_csync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dsync      <= {r_dsync[SYNC_STAGES-2:0], i_ps2_data};
      r_prev       <= w_clk;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (r_state == S_IDLE) begin
        r_wd <= '0;
        if (w_fall && !w_data) begin
          r_sr    <= {w_data, r_sr[10:1]};
          r_cnt   <= 4'd1;
          r_state <= S_SHIFT;
        end
      end else if (r_state == S_SHIFT) begin
        if (w_fall) begin
          r_sr  <= {w_data, r_sr[10:1]};
          r_cnt <= r_cnt + 4'd1;
          r_wd  <= '0;
          if (r_cnt == 4'd10) r_state <= S_CHECK;
        end else if (r_wd == WDW'(TIMEOUT_CYCLES)) begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_wd        <= '0;
          o_frame_err <= 1'b1;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
      end else begin
        r_state      <= S_IDLE;
        r_cnt        <= '0;
        o_byte       <= w_ok ? r_sr[8:1] : o_byte;
        o_byte_valid <= w_ok;
        o_frame_err  <= ~w_ok;
      end
    end
  end
endmodule

// File: rtl/ps2_keycode_decoder.sv
// ps2_keycode_decoder: assembles E0/F0 prefixed PS/2 bytes into held {break, extended, scan} keycodes
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [9:0] o_keycode,
  output logic       o_keycode_valid,
  output logic       o_frame_err,
  output logic       o_busy
);
  logic [7:0] w_byte;
  logic       w_byte_valid, w_rx_err;
  logic       r_brk, r_ext;
  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_rx (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ps2_clk(i_ps2_clk), .i_ps2_data(i_ps2_data),
    .o_byte(w_byte), .o_byte_valid(w_byte_valid), .o_frame_err(w_rx_err), .o_busy(o_busy)
  );
  // Prefix flags accumulate in any order and are consumed by the next real scan code
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_keycode       <= '0;
      o_keycode_valid <= 1'b0;
      o_frame_err     <= 1'b0;
      r_brk           <= 1'b0;
      r_ext           <= 1'b0;
    end else begin
      o_keycode_valid <= 1'b0;
      o_frame_err     <= w_rx_err;
      if (w_rx_err) begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end else if (w_byte_valid) begin
        if (w_byte == PS2_EXT) r_ext <= 1'b1;
        else if (w_byte == PS2_BRK) r_brk <= 1'b1;
        else if (!is_discard(w_byte)) begin
          o_keycode       <= {r_brk, r_ext, w_byte};
          o_keycode_valid <= 1'b1;
          r_brk           <= 1'b0;
          r_ext           <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/ps2_keycode_decoder.md
Name: ps2_keycode_decoder

Overview:
Upstream stage of the fighter controller. Receives raw PS/2 keyboard frames, assembles make/break/extended prefix sequences, and presents one 10-bit keycode {break, extended, scan[7:0]}. Output is held between updates, as the controller FSM expects, and is accompanied by a one-cycle strobe. Runs entirely in the system clock domain and oversamples the asynchronous PS/2 lines.

Parameters:
TIMEOUT_CYCLES, 100000, clk cycles without a PS/2 falling edge before a partial frame is aborted (2 ms at 50 MHz)
SYNC_STAGES, 2, synchronizer depth on ps2_clk and ps2_data (minimum 2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
ps2_clk  in  1  raw PS/2 clock from the pin, asynchronous
ps2_data  in  1  raw PS/2 data from the pin, asynchronous
keycode  out  10  [9] break (F0 seen), [8] extended (E0 seen), [7:0] scan code; held until the next decode
keycode_valid  out  1  one-cycle pulse in the cycle keycode updates
frame_err  out  1  one-cycle pulse on a bad frame (start, stop or parity) or on a timeout
busy  out  1  high while a frame is partially received

Behaviour:
- Reset: one clock, synchronous, active-low. All registers clear on a clk edge with rst_n=0. Outputs reset to keycode=0, keycode_valid=0, frame_err=0, busy=0. Synchronizer flops reset to 1 (idle bus). Reset mid-frame discards the partial frame and any pending prefix.
- Sampling: after SYNC_STAGES flops, a falling edge is detected when prev=1 and cur=0 on the synced clock. Data is sampled in that same cycle.
- Frame receiver FSM:
  - IDLE: a falling edge with data=0 captures the start bit, sets bit_cnt=1 and goes to SHIFT. A falling edge with data=1 is ignored (glitch).
  - SHIFT: each falling edge shifts data in LSB first and increments bit_cnt. When bit_cnt reaches 11, go to CHECK.
  - CHECK (one cycle): a frame is valid iff start=0, stop=1 and ^{data[7:0],parity}=1 (odd parity). A valid frame produces byte_valid with the byte; an invalid one pulses frame_err and clears the prefix flags. Always return to IDLE.
- Timeout: a watchdog counter (width clog2(TIMEOUT_CYCLES+1)) resets on every falling edge and counts while in SHIFT. When it reaches TIMEOUT_CYCLES: abort to IDLE, pulse frame_err, clear prefix flags, bit_cnt=0.
- busy is 1 in SHIFT and CHECK, 0 otherwise.
- Prefix assembly on byte_valid:
  - 0xE0 sets ext=1, no output.
  - 0xF0 sets brk=1, no output.
  - 0xAA, 0xFA, 0xEE, 0xFE, 0x00 and 0xFF are discarded; prefix flags are unchanged and there is no output.
  - Any other byte sets keycode={brk,ext,byte}, pulses keycode_valid, then clears brk and ext.
  - Sequence E0 F0 xx gives {1,1,xx}. F0 E0 xx gives the same result (flags are order-independent).
- Latency: fixed at 5 clk from the ps2_clk pin falling edge of the stop bit to keycode_valid. Breakdown: SYNC_STAGES=2, edge register 1, CHECK 1, output register 1.
- keycode_valid and frame_err never assert in the same cycle. A repeated identical code still pulses keycode_valid, and keycode value stays constant.

Decomposition:
- Shared package ps2_pkg holds:
  - keycode bit-index constants (KC_BRK=9, KC_EXT=8).
  - prefix bytes PS2_EXT=8'hE0 and PS2_BRK=8'hF0, plus the discard-byte list.
  - the game key codes (KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT and their _BREAK forms, KEY_1..KEY_6), so the decoder and the controller share one definition.
- Sub-module ps2_frame_rx holds the synchronizer, edge detect, frame FSM and watchdog, and outputs byte/byte_valid/frame_err. The top level adds the prefix assembler and output registers.

Test Plan:
- Frame 0x74 preceded by E0 (E0, 74) -> keycode=10'h174 (KEY_RIGHT), one keycode_valid pulse exactly 5 clk after the stop-bit pin edge; no pulse after the E0 frame.
- Sequence E0, F0, 74 -> keycode=10'h374 (KEY_RIGHT_BREAK). Next frame 0x69 -> keycode=10'h069 (KEY_1), flags cleared.
- Frame 0x69 sent with even parity -> frame_err pulses once, keycode holds its previous value, no keycode_valid. A following E0, 75 -> 10'h175.
- Drive start plus 4 data bits, then idle ps2_clk -> busy=1 until TIMEOUT_CYCLES after the last edge, then frame_err pulse and busy=0. A following clean frame 0x6B -> 10'h06B.
- E0, then 0xFA, then 0x72 -> keycode=10'h172; the 0xFA is discarded and does not clear ext.
- Assert rst_n=0 for 1 clk mid-frame after F0 -> all outputs 0. Clean frame 0x74 afterwards -> 10'h074 (no stale brk).
